// File: rtl/aurora_tx_fifo.sv
// rtl/aurora_tx_fifo.sv - store-and-forward transmit frame buffer in front of the Aurora TX user interface
//
// Purpose:
//   Buffers AXI-S frames from the local source and starts a frame towards the
//   Aurora core only once its tlast is stored. The one exception is a frame
//   longer than the buffer: it is cut through so that it cannot deadlock.
//   A remote pause is honoured only between frames. Dropping channel_up
//   discards everything that is buffered.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   channel_up          link status; low flushes the buffer
//   remote_xoff         far-end pause request, applied at frame boundaries
//   fifo_used           beats held, including the beat presented on o_*
//   frames_pending      complete frames stored but not yet started
//   i_t*                AXI-S input (tready is registered)
//   o_t*                AXI-S output to Aurora TX (first-word-fall-through register)
module aurora_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              channel_up,
  input  logic              remote_xoff,
  output logic [CNT_W-1:0]  fifo_used,
  output logic [CNT_W-1:0]  frames_pending,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_tvalid,
  input  logic              i_tlast,
  output logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              o_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MW = DATA_W + KEEP_W + 1;
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FLUSH} state_e;

  logic [MW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d, used_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic              cut_q, cut_d;
  logic              cut_tl_q, cut_tl_d;
  logic              i_tready_q, i_tready_d;
  logic              o_tvalid_q, o_tvalid_d;
  logic              o_tlast_q, o_tlast_d;
  logic [DATA_W-1:0] o_tdata_q, o_tdata_d;
  logic [KEEP_W-1:0] o_tkeep_q, o_tkeep_d;
  logic              wr_en, rd_fire, full, inc, dec;
  logic [MW-1:0]     wr_word, head_word;

  always_comb begin
    wr_en   = i_tvalid && i_tready_q && channel_up;
    rd_fire = o_tvalid_q && o_tready && channel_up;
    wr_word = {i_tlast, i_tkeep, i_tdata};
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    wptr_d  = wptr_q + (AW + 1)'(wr_en);
    rptr_d  = rptr_q + (AW + 1)'(rd_fire);

    // A cut-through frame starts before its tlast is stored. Its tlast must
    // then neither be counted as a pending frame nor be decremented at its
    // first output beat. cut_tl marks that this tlast has already arrived.
    inc = wr_en && i_tlast && !(cut_q && !cut_tl_q);
    dec = rd_fire && first_q && !cut_q;
    frames_d = frames_q;
    if (inc && !dec) begin
      frames_d = frames_q + 1'b1;
    end else if (dec && !inc) begin
      frames_d = frames_q - 1'b1;
    end
    first_d  = rd_fire ? o_tlast_q : first_q;
    cut_d    = cut_q;
    cut_tl_d = cut_tl_q;
    if (wr_en && i_tlast && cut_q) begin
      cut_tl_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!remote_xoff && (frames_q != '0 || full)) begin
          state_d  = S_SEND;
          cut_d    = (frames_q == '0);
          cut_tl_d = 1'b0;
        end
      end
      S_SEND: begin
        if (rd_fire && o_tlast_q) begin
          state_d  = S_IDLE;
          cut_d    = 1'b0;
          cut_tl_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!channel_up) begin
      state_d  = S_FLUSH;
      wptr_d   = '0;
      rptr_d   = '0;
      frames_d = '0;
      first_d  = 1'b1;
      cut_d    = 1'b0;
      cut_tl_d = 1'b0;
    end

    used_d     = wptr_d - rptr_d;
    i_tready_d = (state_d != S_FLUSH) && (used_d < DEPTH_P);

    // The output register always mirrors the head of the buffer. When the
    // head is being written this very cycle, take it straight from the input.
    head_word = (wr_en && (wptr_q == rptr_d)) ? wr_word : mem_q[rptr_d[AW-1:0]];
    o_tvalid_d = (state_d == S_SEND) && (wptr_d != rptr_d);
    o_tdata_d  = o_tdata_q;
    o_tkeep_d  = o_tkeep_q;
    o_tlast_d  = o_tlast_q;
    if (o_tvalid_d) begin
      {o_tlast_d, o_tkeep_d, o_tdata_d} = head_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      frames_q   <= '0;
      state_q    <= S_IDLE;
      first_q    <= 1'b1;
      cut_q      <= 1'b0;
      cut_tl_q   <= 1'b0;
      i_tready_q <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      o_tdata_q  <= '0;
      o_tkeep_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      frames_q   <= frames_d;
      state_q    <= state_d;
      first_q    <= first_d;
      cut_q      <= cut_d;
      cut_tl_q   <= cut_tl_d;
      i_tready_q <= i_tready_d;
      o_tvalid_q <= o_tvalid_d;
      o_tlast_q  <= o_tlast_d;
      o_tdata_q  <= o_tdata_d;
      o_tkeep_q  <= o_tkeep_d;
    end
  end

  assign fifo_used      = CNT_W'(wptr_q - rptr_q);
  assign frames_pending = frames_q;
  assign i_tready       = i_tready_q;
  assign o_tvalid       = o_tvalid_q;
  assign o_tlast        = o_tlast_q;
  assign o_tdata        = o_tdata_q;
  assign o_tkeep        = o_tkeep_q;

endmodule

// File: tb/tb_aurora_tx_fifo.sv
// tb/tb_aurora_tx_fifo.sv - randomized self-checking bench for aurora_tx_fifo
module tb_aurora_tx_fifo;

  localparam int DW = 8;
  localparam int KW = 1;
  localparam int CW = 7;
  localparam int TMO = 3000;

  logic          clk = 1'b0;
  logic          rst_n, channel_up, remote_xoff;
  logic [CW-1:0] fifo_used, frames_pending;
  logic [DW-1:0] i_tdata, o_tdata;
  logic [KW-1:0] i_tkeep, o_tkeep;
  logic          i_tvalid, i_tlast, i_tready;
  logic          o_tvalid, o_tlast, o_tready;

  aurora_tx_fifo #(.DATA_W(DW), .KEEP_W(KW), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .channel_up(channel_up), .remote_xoff(remote_xoff),
    .fifo_used(fifo_used), .frames_pending(frames_pending),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
    .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted beat in arrival order; the buffer must
  // hand out exactly this sequence unless a reset or link drop discards it.
  logic [DW+KW:0] model_q[$];
  bit  started = 0;
  bit  mon_en = 0;
  int  delivered = 0;
  int  peak = 0;
  bit  rdy_rand = 0;

  function automatic int model_pending();
    int lasts = 0;
    foreach (model_q[i]) if (model_q[i][DW+KW]) lasts++;
    if (started && lasts > 0) lasts--;
    return lasts;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW+KW:0] b;
      check_eq("fifo_used", 32'(fifo_used), model_q.size());
      check_eq("frames_pending", 32'(frames_pending), model_pending());
      if (int'(frames_pending) > peak) peak = int'(frames_pending);
      if (!rst_n || !channel_up) begin
        model_q.delete();
        started = 0;
      end else begin
        if (o_tvalid && o_tready) begin
          check_eq("beat_expected", 32'(model_q.size() != 0), 1);
          if (model_q.size() != 0) begin
            b = model_q.pop_front();
            check_eq("o_tdata", 32'(o_tdata), 32'(b[DW-1:0]));
            check_eq("o_tkeep", 32'(o_tkeep), 32'(b[DW+KW-1:DW]));
            check_eq("o_tlast", 32'(o_tlast), 32'(b[DW+KW]));
            started = !b[DW+KW];
            delivered++;
          end
        end
        if (i_tvalid && i_tready) model_q.push_back({i_tlast, i_tkeep, i_tdata});
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) o_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int  n = 0;
    bit  hs = 0;
    i_tdata = d; i_tkeep = k; i_tlast = l; i_tvalid = 1'b1;
    while (!hs && n < TMO) begin
      @(negedge clk);
      hs = i_tready;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("send_timeout", 32'(hs), 1);
    i_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit gaps, input bit with_last);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) cyc(1);
      send_beat(DW'($urandom), KW'($urandom), with_last && (i == len - 1));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((model_q.size() != 0 || frames_pending != 0) && n < TMO) begin
      cyc(1);
      n++;
    end
    check_eq("drain_timeout", 32'(model_q.size()), 0);
    cyc(3);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (delivered < target && n < TMO) begin
      cyc(1);
      n++;
    end
    check_eq("wait_beats", 32'(delivered >= target), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_i_tready"}, 32'(i_tready), 0);
    check_eq({tag, "_o_tvalid"}, 32'(o_tvalid), 0);
    check_eq({tag, "_o_tlast"}, 32'(o_tlast), 0);
    check_eq({tag, "_o_tdata"}, 32'(o_tdata), 0);
    check_eq({tag, "_o_tkeep"}, 32'(o_tkeep), 0);
    check_eq({tag, "_fifo_used"}, 32'(fifo_used), 0);
    check_eq({tag, "_frames_pending"}, 32'(frames_pending), 0);
  endtask

  int base, vcnt, n;

  initial begin
    rst_n = 1'b0; channel_up = 1'b1; remote_xoff = 1'b0;
    i_tdata = '0; i_tkeep = '0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
    cyc(3);
    check_reset_vals("reset");
    mon_en = 1;
    rst_n = 1'b1;
    cyc(2);

    // 1: three 10-beat frames, each sent into an idle buffer; latency 2 clk
    o_tready = 1'b1;
    peak = 0;
    base = delivered;
    for (int f = 0; f < 3; f++) begin
      send_frame(10, 0, 1);
      check_eq("lat_n1_valid", 32'(o_tvalid), 0);
      cyc(1);
      check_eq("lat_n2_valid", 32'(o_tvalid), 1);
      wait_drain();
    end
    check_eq("t1_beats", delivered - base, 30);
    check_eq("t1_peak_le3", 32'(peak <= 3), 1);
    check_eq("t1_pending_end", 32'(frames_pending), 0);

    // 2: five 40-beat frames with random input gaps and random o_tready
    rdy_rand = 1;
    base = delivered;
    for (int f = 0; f < 5; f++) send_frame(40, 1, 1);
    wait_drain();
    check_eq("t2_beats", delivered - base, 200);
    rdy_rand = 0;
    cyc(1);

    // 3: pause raised on beat 5 of the outgoing frame
    o_tready = 1'b0;
    send_frame(20, 0, 1);
    send_frame(20, 0, 1);
    base = delivered;
    o_tready = 1'b1;
    wait_beats(base + 5);
    remote_xoff = 1'b1;
    wait_beats(base + 20);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (o_tvalid) vcnt++;
    end
    check_eq("t3_paused_valid", vcnt, 0);
    check_eq("t3_first_frame", delivered - base, 20);
    check_eq("t3_pending_held", 32'(frames_pending), 1);
    remote_xoff = 1'b0;
    wait_drain();
    check_eq("t3_beats", delivered - base, 40);

    // 4: 100-beat frame forces cut-through
    o_tready = 1'b0;
    base = delivered;
    fork
      send_frame(100, 0, 1);
      begin
        n = 0;
        while (fifo_used != 7'd64 && n < TMO) begin
          cyc(1);
          n++;
        end
        cyc(3);
        check_eq("t4_full_used", 32'(fifo_used), 64);
        check_eq("t4_full_ready", 32'(i_tready), 0);
        check_eq("t4_cut_valid", 32'(o_tvalid), 1);
        check_eq("t4_cut_pending", 32'(frames_pending), 0);
        o_tready = 1'b1;
      end
    join
    wait_drain();
    check_eq("t4_beats", delivered - base, 100);

    // 5: link drop with 30 beats stored
    o_tready = 1'b0;
    send_frame(10, 0, 1);
    send_frame(20, 0, 0);
    cyc(2);
    check_eq("t5_pre_valid", 32'(o_tvalid), 1);
    check_eq("t5_pre_used", 32'(fifo_used), 30);
    channel_up = 1'b0;
    cyc(1);
    check_eq("t5_drop_valid", 32'(o_tvalid), 0);
    check_eq("t5_drop_used", 32'(fifo_used), 0);
    check_eq("t5_drop_pending", 32'(frames_pending), 0);
    cyc(2);
    check_eq("t5_drop_ready", 32'(i_tready), 0);
    channel_up = 1'b1;
    o_tready = 1'b1;
    cyc(2);
    base = delivered;
    send_frame(8, 1, 1);
    wait_drain();
    check_eq("t5_beats", delivered - base, 8);

    // 6: one-cycle reset in the middle of a transfer
    rdy_rand = 1;
    send_frame(10, 0, 1);
    wait_beats(delivered + 3);
    rst_n = 1'b0;
    cyc(1);
    check_reset_vals("t6");
    rst_n = 1'b1;
    cyc(2);
    base = delivered;
    for (int f = 0; f < 3; f++) send_frame(12, 1, 1);
    wait_drain();
    check_eq("t6_beats", delivered - base, 36);
    rdy_rand = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
